specinvert_detect: RTL and testbench
====================================

SPECINVERT_DETECT -- requirements
Module: specinvert_detect

Interface
REQ-001 SHALL be clocked by a single clock and use a synchronous, active-low reset.
REQ-002 SHALL expose: axis_data_clk  in  1  sole clock.
REQ-003 SHALL expose: axis_data_rst_n  in  1  synchronous active-low reset.
REQ-004 SHALL expose: s_axis_tdata  in  32  sc16 sample, [31:16]=Q, [15:0]=I.
REQ-005 SHALL expose: s_axis_tlast, s_axis_teob  in  1 each  packet end, burst end.
REQ-006 SHALL expose: s_axis_tvalid  in  1;  s_axis_tready  out  1.
REQ-007 SHALL expose: m_axis_tdata  out  32;  m_axis_tlast, m_axis_teob, m_axis_tvalid  out  1 each;  m_axis_tready  in  1.
REQ-008 SHALL expose: cfg_enable  in  1  detection enable.
REQ-009 SHALL expose: cfg_threshold  in  32  unsigned decision threshold.
REQ-010 SHALL expose: cfg_window  in  16  samples per detection window.
REQ-011 SHALL expose: invert_req  out  1  latched decision, 1 = spectrum inverted.
REQ-012 SHALL expose: decision_valid  out  1  one-cycle pulse per completed window.
REQ-013 SHALL expose: low_conf  out  1  last window within the threshold band.
REQ-014 SHALL expose: metric  out  32  accumulator bits [48:17] of the last window.
REQ-015 SHALL expose: windows_done  out  16  wrapping count of completed windows.

Function
REQ-016 Stream path SHALL be zero-latency pass-through: m_axis_* = s_axis_*, s_axis_tready = m_axis_tready; data never modified.
REQ-017 A sample SHALL count as accepted only when s_axis_tvalid && s_axis_tready.
REQ-018 Per accepted sample, cross = Q[n]*I[n-1] - I[n]*Q[n-1]; 16x16 signed products give 32 bits and the difference gives 33 bits, all signed.
REQ-019 Previous sample (I[n-1],Q[n-1]) SHALL reset to 0 and clear to 0 after any accepted beat with teob=1.
REQ-020 Pipeline: products registered (stage 1); subtract-and-accumulate into a 49-bit signed accumulator (stage 2); no saturation is needed.
REQ-021 FSM states SHALL be IDLE, ACCUM, FLUSH, REPORT.
REQ-022 IDLE: accumulator=0 and counter=0; go to ACCUM when cfg_enable=1; latch cfg_window, with 0 treated as 1.
REQ-023 ACCUM: accumulate each accepted sample; on the accepted sample where count = window-1, go to FLUSH.
REQ-024 FLUSH: 2 cycles for the pipeline to drain; samples accepted during FLUSH update the previous-sample register only and are excluded from every window.
REQ-025 REPORT (1 cycle) SHALL evaluate T = {cfg_threshold,16'b0} zero-extended to 49 bits:
- acc > T: invert_req=0, low_conf=0.
- acc < -T: invert_req=1, low_conf=0.
- otherwise: invert_req held, low_conf=1.
REQ-026 REPORT SHALL also pulse decision_valid, load metric, increment windows_done (wrapping at 0xFFFF→0), clear the accumulator and counter, relatch cfg_window, then go to ACCUM if cfg_enable=1, else IDLE.
REQ-027 Deasserting cfg_enable in ACCUM SHALL abort the window (no report) and return to IDLE; outputs are held.
REQ-028 cfg_window/cfg_threshold changes mid-window SHALL NOT affect the current window's length.
REQ-029 Backpressure (m_axis_tready=0) SHALL stall accumulation; no sample is counted twice.

Reset
REQ-030 On reset: state=IDLE, accumulator/counter/previous sample=0, invert_req=0, decision_valid=0, low_conf=0, metric=0, windows_done=0.
REQ-031 Reset mid-window SHALL discard the partial window with no decision_valid pulse; the pass-through path stays combinational throughout.

Structure
REQ-032 A package specinvert_pkg SHALL hold the FSM state enum, ACC_W=49, and the default window of 1024.
REQ-033 One sub-module, specinvert_xprod (registered cross-product stage), SHALL be instantiated.

Verification
REQ-034 Window 16, threshold 1, tone (1000,0),(0,1000),(-1000,0),(0,-1000) repeated -> metric from acc=15e6, invert_req=0, low_conf=0, decision_valid once.
REQ-035 Same settings, reverse rotation (1000,0),(0,-1000),(-1000,0),(0,1000) -> acc=-15e6, invert_req=1.
REQ-036 All-zero input after REQ-035 -> low_conf=1, invert_req stays 1, windows_done increments.
REQ-037 Tone with m_axis_tready toggled at 50% -> identical accumulator result to the unstalled case, output data bit-exact with the input.
REQ-038 teob asserted on the 8th sample -> sample 9 contributes 0 and acc=14e6.
REQ-039 Reset asserted at sample 10 of a window -> no decision_valid pulse, all outputs at reset values, next full window reports normally.

Source files
------------

// File: rtl/specinvert_pkg.sv
// Shared types and constants for the spectrum-inversion detector.
// Holds the window FSM encoding and accumulator sizing.
package specinvert_pkg;

    localparam int          ACC_W      = 49;
    localparam logic [15:0] DEF_WINDOW = 16'd1024;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/specinvert_xprod.sv
// Registered cross-product stage: Q[n]*I[n-1] and I[n]*Q[n-1].
// Also owns the previous-sample register, cleared at burst end.
module specinvert_xprod
    import specinvert_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_accept,
    input  logic               i_count,
    input  logic               i_eob,
    input  logic [31:0]        i_data,
    output logic               o_valid,
    output logic signed [31:0] o_p_qi,
    output logic signed [31:0] o_p_iq
);

    logic signed [15:0] w_i;
    logic signed [15:0] w_q;
    logic signed [15:0] r_prev_i;
    logic signed [15:0] r_prev_q;
    logic signed [31:0] r_p_qi;
    logic signed [31:0] r_p_iq;
    logic               r_valid;

    assign w_i = i_data[15:0];
    assign w_q = i_data[31:16];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev_i <= '0;
            r_prev_q <= '0;
            r_p_qi   <= '0;
            r_p_iq   <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= i_accept & i_count;
            if (i_accept) begin
                r_p_qi   <= w_q * r_prev_i;
                r_p_iq   <= w_i * r_prev_q;
                // burst end breaks phase continuity for the next sample
                r_prev_i <= i_eob ? 16'sd0 : w_i;
                r_prev_q <= i_eob ? 16'sd0 : w_q;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_p_qi  = r_p_qi;
    assign o_p_iq  = r_p_iq;

endmodule

// File: rtl/specinvert_detect.sv
// Spectrum-inversion detector on a pass-through sc16 stream.
// Accumulates the I/Q cross product per window and decides rotation sense.
module specinvert_detect
    import specinvert_pkg::*;
(
    input  logic        axis_data_clk,
    input  logic        axis_data_rst_n,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_teob,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_teob,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    input  logic        cfg_enable,
    input  logic [31:0] cfg_threshold,
    input  logic [15:0] cfg_window,
    output logic        invert_req,
    output logic        decision_valid,
    output logic        low_conf,
    output logic [31:0] metric,
    output logic [15:0] windows_done
);

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [15:0]               r_count;
    logic [15:0]               r_window;
    logic                      r_flush;
    logic                      r_invert;
    logic                      r_dv;
    logic                      r_low;
    logic [31:0]               r_metric;
    logic [15:0]               r_done;

    logic                      w_accept;
    logic                      w_count;
    logic                      w_xv;
    logic signed [31:0]        w_p_qi;
    logic signed [31:0]        w_p_iq;
    logic signed [32:0]        w_cross;
    logic signed [ACC_W-1:0]   w_thr;
    logic [15:0]               w_win_lat;
    logic                      w_last;
    logic                      w_gt;
    logic                      w_lt;

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_teob   = s_axis_teob;
    assign m_axis_tvalid = s_axis_tvalid;
    assign s_axis_tready = m_axis_tready;

    assign w_accept = s_axis_tvalid & m_axis_tready;
    assign w_count  = (r_state == ST_ACCUM) & cfg_enable;

    specinvert_xprod u_xprod (
        .clk      (axis_data_clk),
        .rst_n    (axis_data_rst_n),
        .i_accept (w_accept),
        .i_count  (w_count),
        .i_eob    (s_axis_teob),
        .i_data   (s_axis_tdata),
        .o_valid  (w_xv),
        .o_p_qi   (w_p_qi),
        .o_p_iq   (w_p_iq)
    );

    assign w_cross   = {w_p_qi[31], w_p_qi} - {w_p_iq[31], w_p_iq};
    assign w_thr     = {1'b0, cfg_threshold, 16'h0000};
    assign w_win_lat = (cfg_window == 16'd0) ? 16'd1 : cfg_window;
    assign w_last    = (r_count == r_window - 16'd1);
    assign w_gt      = r_acc > w_thr;
    assign w_lt      = r_acc < -w_thr;

    always_ff @(posedge axis_data_clk) begin
        if (!axis_data_rst_n) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_count  <= '0;
            r_window <= DEF_WINDOW;
            r_flush  <= 1'b0;
            r_invert <= 1'b0;
            r_dv     <= 1'b0;
            r_low    <= 1'b0;
            r_metric <= '0;
            r_done   <= '0;
        end else begin
            r_dv <= 1'b0;
            if (w_xv) begin
                r_acc <= r_acc + {{(ACC_W-33){w_cross[32]}}, w_cross};
            end
            unique case (r_state)
                ST_IDLE: begin
                    r_acc    <= '0;
                    r_count  <= '0;
                    r_window <= w_win_lat;
                    if (cfg_enable) r_state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (!cfg_enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_accept) begin
                        r_count <= r_count + 16'd1;
                        if (w_last) begin
                            r_state <= ST_FLUSH;
                            r_flush <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    // two cycles let the last product reach the accumulator
                    r_flush <= ~r_flush;
                    if (r_flush) r_state <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (w_gt) begin
                        r_invert <= 1'b0;
                        r_low    <= 1'b0;
                    end else if (w_lt) begin
                        r_invert <= 1'b1;
                        r_low    <= 1'b0;
                    end else begin
                        r_low    <= 1'b1;
                    end
                    r_dv     <= 1'b1;
                    r_metric <= r_acc[48:17];
                    r_done   <= r_done + 16'd1;
                    r_acc    <= '0;
                    r_count  <= '0;
                    r_window <= w_win_lat;
                    r_state  <= cfg_enable ? ST_ACCUM : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign invert_req     = r_invert;
    assign decision_valid = r_dv;
    assign low_conf       = r_low;
    assign metric         = r_metric;
    assign windows_done   = r_done;

endmodule

// File: tb/tb_specinvert_detect.sv
// Directed bench for specinvert_detect: tones, stall, burst end, reset.
// Expected metrics are hand-computed floor(acc / 2^17).
module tb_specinvert_detect;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_teob;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_teob;
    logic        m_tvalid;
    logic        m_tready;
    logic        cfg_enable;
    logic [31:0] cfg_threshold;
    logic [15:0] cfg_window;
    logic        invert_req;
    logic        decision_valid;
    logic        low_conf;
    logic [31:0] metric;
    logic [15:0] windows_done;

    int n_checks = 0;
    int n_errors = 0;
    int dv_cnt   = 0;
    logic stall  = 1'b0;

    logic signed [15:0] tone_i [4] = '{16'sd1000, 16'sd0, -16'sd1000, 16'sd0};
    logic signed [15:0] tone_q [4] = '{16'sd0, 16'sd1000, 16'sd0, -16'sd1000};

    specinvert_detect dut (
        .axis_data_clk   (clk),
        .axis_data_rst_n (rst_n),
        .s_axis_tdata    (s_tdata),
        .s_axis_tlast    (s_tlast),
        .s_axis_teob     (s_teob),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tready   (s_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tlast    (m_tlast),
        .m_axis_teob     (m_teob),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready),
        .cfg_enable      (cfg_enable),
        .cfg_threshold   (cfg_threshold),
        .cfg_window      (cfg_window),
        .invert_req      (invert_req),
        .decision_valid  (decision_valid),
        .low_conf        (low_conf),
        .metric          (metric),
        .windows_done    (windows_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (decision_valid) dv_cnt++;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic eob);
        s_tdata  = d;
        s_tlast  = eob;
        s_teob   = eob;
        s_tvalid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            m_tready = stall ? ~m_tready : 1'b1;
            #1;
            if (stall) begin
                check("pass_data", m_tdata, d);
                check("pass_ready", s_tready, m_tready);
            end
            @(posedge clk);
            if (m_tready) begin
                #1;
                return;
            end
            #1;
        end
        check("send_timeout", 0, 1);
    endtask

    // mode 0 forward tone, 1 reverse tone, 2 zeros
    task automatic send_samples(input int mode, input int n, input int eob_at);
        logic signed [15:0] si;
        logic signed [15:0] sq;
        for (int k = 0; k < n; k++) begin
            si = tone_i[k % 4];
            sq = tone_q[k % 4];
            if (mode == 1) sq = -sq;
            if (mode == 2) begin
                si = 16'sd0;
                sq = 16'sd0;
            end
            send({sq, si}, (k == eob_at) || (k == 15));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_teob   = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic run_window(input string tag, input int mode, input int eob_at,
                              input logic [31:0] exp_metric, input logic exp_inv,
                              input logic exp_low, input logic [15:0] exp_done);
        int base;
        bit seen;
        base = dv_cnt;
        seen = 1'b0;
        send_samples(mode, 16, eob_at);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (decision_valid) seen = 1'b1;
        end
        check({tag, "_report_seen"}, seen, 1'b1);
        check({tag, "_metric"}, metric, exp_metric);
        check({tag, "_invert"}, invert_req, exp_inv);
        check({tag, "_low_conf"}, low_conf, exp_low);
        check({tag, "_done"}, windows_done, exp_done);
        repeat (3) @(negedge clk);
        check({tag, "_dv_once"}, dv_cnt - base, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst_n         = 1'b0;
        s_tdata       = '0;
        s_tlast       = 1'b0;
        s_teob        = 1'b0;
        s_tvalid      = 1'b0;
        m_tready      = 1'b1;
        cfg_enable    = 1'b1;
        cfg_threshold = 32'd1;
        cfg_window    = 16'd16;
        repeat (3) @(posedge clk);
        #1;
        check("rst_invert", invert_req, 1'b0);
        check("rst_dv", decision_valid, 1'b0);
        check("rst_low", low_conf, 1'b0);
        check("rst_metric", metric, 32'd0);
        check("rst_done", windows_done, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        run_window("fwd", 0, -1, 32'd114, 1'b0, 1'b0, 16'd1);
        run_window("rev", 1, -1, 32'hFFFF_FF8D, 1'b1, 1'b0, 16'd2);
        run_window("zero", 2, -1, 32'd0, 1'b1, 1'b1, 16'd3);

        base = dv_cnt;
        send_samples(0, 10, -1);
        rst_n    = 1'b0;
        s_tvalid = 1'b1;
        @(negedge clk);
        check("rst_pass_valid", m_tvalid, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        check("mid_rst_invert", invert_req, 1'b0);
        check("mid_rst_low", low_conf, 1'b0);
        check("mid_rst_metric", metric, 32'd0);
        check("mid_rst_done", windows_done, 16'd0);
        check("mid_rst_dv", decision_valid, 1'b0);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("mid_rst_no_pulse", dv_cnt - base, 0);

        run_window("post_rst", 0, -1, 32'd114, 1'b0, 1'b0, 16'd1);
        stall = 1'b1;
        run_window("stall", 0, -1, 32'd114, 1'b0, 1'b0, 16'd2);
        stall = 1'b0;
        run_window("eob8", 0, 7, 32'd106, 1'b0, 1'b0, 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
